// File: rtl/mem_responder.sv
// mem_responder: byte-strobed word RAM plus a four-register MMIO window (console FIFO, tohost/halt, cycle counter, scratch)
module mem_responder #(
  parameter int                ADDR_W     = 10,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 10'h3FC,
  parameter string             INIT_FILE  = ""
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [ADDR_W-1:0] mem_V_address0,
  input  logic              mem_V_ce0,
  input  logic              mem_V_we0,
  input  logic [31:0]       mem_V_d0,
  input  logic [3:0]        pstrb_V,
  output logic [31:0]       mem_V_q0,
  output logic [7:0]        con_tdata,
  output logic              con_tvalid,
  input  logic              con_tready,
  output logic              halt,
  output logic [30:0]       exit_code
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int DEPTH = int'(MMIO_BASE);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  logic [31:0]       ram [DEPTH];
  logic [7:0]        fifo [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              ovf;
  logic [31:0]       tohost, cycle, scratch;
  logic              acc_wr, acc_rd, is_ram, is_mmio;
  logic [ADDR_W-1:0] off;
  logic [1:0]        k;
  logic              wr_con, wr_toh, wr_scr;
  logic              full, pop, push_req, push, ovf_set, ovf_clr;
  logic [3:0]        cnt4;
  logic [31:0]       mmio_rd, rdata, toh_new;

  assign acc_wr  = mem_V_ce0 & mem_V_we0;
  assign acc_rd  = mem_V_ce0 & ~mem_V_we0;
  assign off     = mem_V_address0 - MMIO_BASE;
  assign is_ram  = mem_V_address0 < MMIO_BASE;
  assign is_mmio = ~is_ram & (off[ADDR_W-1:2] == '0);
  assign k       = off[1:0];
  assign wr_con  = acc_wr & is_mmio & (k == 2'd0);
  assign wr_toh  = acc_wr & is_mmio & (k == 2'd1);
  assign wr_scr  = acc_wr & is_mmio & (k == 2'd3);

  assign con_tvalid = count != '0;
  assign con_tdata  = con_tvalid ? fifo[rd_ptr] : 8'h00;
  assign full       = count == CW'(FIFO_DEPTH);
  assign pop        = con_tvalid & con_tready;
  assign push_req   = wr_con & pstrb_V[0];
  assign push       = push_req & (~full | pop);
  assign ovf_set    = push_req & full & ~pop;
  assign ovf_clr    = wr_con & pstrb_V[1] & mem_V_d0[8];
  assign cnt4       = 4'(count);

  assign toh_new   = merge(tohost, mem_V_d0, pstrb_V);
  assign exit_code = tohost[31:1];
  assign mmio_rd   = k == 2'd0 ? {23'b0, ovf, 4'b0, cnt4} :
                     k == 2'd1 ? tohost :
                     k == 2'd2 ? cycle : scratch;
  assign rdata     = is_ram ? ram[mem_V_address0] : is_mmio ? mmio_rd : 32'h0;

  always_ff @(posedge ap_clk) begin
    if (acc_wr & is_ram)
      for (int i = 0; i < 4; i++)
        if (pstrb_V[i]) ram[mem_V_address0][8*i +: 8] <= mem_V_d0[8*i +: 8];
  end

  always_ff @(posedge ap_clk) begin
    if (push) fifo[wr_ptr] <= mem_V_d0[7:0];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mem_V_q0 <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      tohost   <= '0;
      halt     <= 1'b0;
      cycle    <= '0;
      scratch  <= '0;
    end else begin
      if (acc_rd) mem_V_q0 <= rdata;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      ovf   <= (ovf & ~ovf_clr) | ovf_set;
      if (wr_toh & ~halt) begin
        tohost <= toh_new;
        halt   <= toh_new[0];
      end
      if (~halt) cycle <= cycle + 32'd1;
      if (wr_scr) scratch <= merge(scratch, mem_V_d0, pstrb_V);
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven RAM/scratch vectors plus directed console, halt and reset sequences
module tb_mem_responder;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [9:0]  addr = '0;
    logic        ce = 1'b0, we = 1'b0;
    logic [31:0] d = '0;
    logic [3:0]  strb = '0;
    logic [31:0] q0;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        halt;
    logic [30:0] exit_code;
    int          errors = 0, checks = 0;
    logic [31:0] ecount = 0;

    mem_responder dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .mem_V_address0(addr), .mem_V_ce0(ce),
        .mem_V_we0(we), .mem_V_d0(d), .pstrb_V(strb), .mem_V_q0(q0),
        .con_tdata(tdata), .con_tvalid(tvalid), .con_tready(tready),
        .halt(halt), .exit_code(exit_code)
    );

    always #5 ap_clk = ~ap_clk;

    // Edges seen since reset release: the expected cycle counter value while running.
    always @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) ecount <= 0; else ecount <= ecount + 1;

    typedef struct {
        logic        ce;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] d;
        logic [3:0]  strb;
        logic [31:0] q;
    } vec_t;

    function automatic vec_t mk(logic c, logic w, logic [9:0] a, logic [31:0] dd, logic [3:0] s, logic [31:0] q);
        vec_t v;
        v.ce = c; v.we = w; v.addr = a; v.d = dd; v.strb = s; v.q = q;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] dd, input logic [3:0] s);
        ce = 1'b1; we = 1'b1; addr = a; d = dd; strb = s;
        @(posedge ap_clk); #1;
        ce = 1'b0; we = 1'b0; strb = '0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] v);
        ce = 1'b1; we = 1'b0; addr = a;
        @(posedge ap_clk); #1;
        v = q0; ce = 1'b0;
    endtask

    vec_t        vecs [15];
    logic [31:0] v, exp_c;
    logic [7:0]  dq [8];

    initial begin
        vecs[0]  = mk(1, 1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0);
        vecs[1]  = mk(1, 1, 10'h010, 32'h0000AA00, 4'h2, 32'h0);
        vecs[2]  = mk(1, 0, 10'h010, 32'h0,        4'h0, 32'hDEADAAEF);
        vecs[3]  = mk(1, 1, 10'h011, 32'h11223344, 4'hF, 32'hDEADAAEF);
        vecs[4]  = mk(1, 1, 10'h011, 32'hCAFEF00D, 4'h0, 32'hDEADAAEF);
        vecs[5]  = mk(1, 0, 10'h011, 32'h0,        4'h0, 32'h11223344);
        vecs[6]  = mk(1, 1, 10'h3FF, 32'h12345678, 4'hF, 32'h11223344);
        vecs[7]  = mk(1, 1, 10'h3FF, 32'h000000AB, 4'h1, 32'h11223344);
        vecs[8]  = mk(1, 0, 10'h3FF, 32'h0,        4'h0, 32'h123456AB);
        vecs[9]  = mk(1, 1, 10'h3FF, 32'hFF000000, 4'h8, 32'h123456AB);
        vecs[10] = mk(1, 0, 10'h3FF, 32'h0,        4'h0, 32'hFF3456AB);
        vecs[11] = mk(1, 0, 10'h010, 32'h0,        4'h0, 32'hDEADAAEF);
        vecs[12] = mk(0, 0, 10'h011, 32'h0,        4'h0, 32'hDEADAAEF);
        vecs[13] = mk(1, 0, 10'h3FC, 32'h0,        4'h0, 32'h0);
        vecs[14] = mk(1, 0, 10'h3FD, 32'h0,        4'h0, 32'h0);
        dq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h5A};

        repeat (2) @(posedge ap_clk);
        #1;
        chk("reset_q0", q0, 32'h0);
        chk("reset_tvalid", 32'(tvalid), 32'h0);
        chk("reset_tdata", 32'(tdata), 32'h0);
        chk("reset_halt", 32'(halt), 32'h0);
        ap_rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            ce = vecs[i].ce; we = vecs[i].we; addr = vecs[i].addr; d = vecs[i].d; strb = vecs[i].strb;
            @(posedge ap_clk); #1;
            chk($sformatf("vec%0d_q0", i), q0, vecs[i].q);
        end
        ce = 1'b0; we = 1'b0; strb = '0;

        wr(10'h3FC, 32'h48, 4'h1);
        wr(10'h3FC, 32'h69, 4'h1);
        chk("con_tvalid", 32'(tvalid), 32'h1);
        chk("con_head", 32'(tdata), 32'h48);
        rd(10'h3FC, v);
        chk("con_count2", v, 32'h2);
        tready = 1'b1;
        @(posedge ap_clk); #1;
        chk("con_second", 32'(tdata), 32'h69);
        @(posedge ap_clk); #1;
        chk("con_drained", 32'(tvalid), 32'h0);
        tready = 1'b0;

        for (int i = 0; i < 9; i++) wr(10'h3FC, 32'h30 + 32'(i), 4'h1);
        rd(10'h3FC, v);
        chk("ovf_full", v, 32'h108);
        wr(10'h3FC, 32'h100, 4'h2);
        rd(10'h3FC, v);
        chk("ovf_cleared", v, 32'h8);
        chk("ovf_head", 32'(tdata), 32'h30);

        tready = 1'b1;
        wr(10'h3FC, 32'h5A, 4'h1);
        tready = 1'b0;
        rd(10'h3FC, v);
        chk("full_poppush_count", v, 32'h8);
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), 32'(tdata), 32'(dq[i]));
            @(posedge ap_clk); #1;
        end
        chk("drain_empty", 32'(tvalid), 32'h0);
        tready = 1'b0;

        exp_c = ecount;
        rd(10'h3FE, v);
        chk("cycle_run", v, exp_c);
        wr(10'h3FD, 32'h1, 4'hF);
        exp_c = ecount;
        chk("halt_set", 32'(halt), 32'h1);
        chk("exit_pass", 32'(exit_code), 32'h0);
        repeat (3) @(posedge ap_clk);
        #1;
        rd(10'h3FE, v);
        chk("cycle_frozen", v, exp_c);
        wr(10'h3FD, 32'h7, 4'hF);
        wr(10'h3FE, 32'h0, 4'hF);
        rd(10'h3FD, v);
        chk("tohost_locked", v, 32'h1);
        rd(10'h3FE, v);
        chk("cycle_ro", v, exp_c);

        #3 ap_rst_n = 1'b0;
        #3 ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        wr(10'h3FD, 32'h4, 4'hF);
        chk("halt_even", 32'(halt), 32'h0);
        rd(10'h3FD, v);
        chk("tohost_rd", v, 32'h4);
        wr(10'h3FD, 32'h5, 4'h1);
        chk("halt_fail", 32'(halt), 32'h1);
        chk("exit_code2", 32'(exit_code), 32'h2);

        wr(10'h020, 32'h55AA55AA, 4'hF);
        for (int i = 0; i < 3; i++) wr(10'h3FC, 32'h41 + 32'(i), 4'h1);
        rd(10'h020, v);
        chk("pre_reset_q0", v, 32'h55AA55AA);
        #3 ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(tvalid), 32'h0);
        chk("mid_rst_q0", q0, 32'h0);
        chk("mid_rst_halt", 32'(halt), 32'h0);
        #3 ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        rd(10'h020, v);
        chk("ram_survives", v, 32'h55AA55AA);
        rd(10'h3FC, v);
        chk("con_after_rst", v, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
